// File: rtl/signed_div_if.sv
// Handshake and data bundle for the sequential signed divider.
interface signed_div_if #(
  parameter int unsigned W = 5
);
  logic             start;
  logic [2*W-1:0]   Dividend;
  logic [W-1:0]     Divisor;
  logic [2*W-1:0]   Quotient;
  logic [W-1:0]     Remainder;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic             ovf;

  // Requester side: issues operands and start, observes results.
  modport master (
    output start, Dividend, Divisor,
    input  Quotient, Remainder, busy, done, div_zero, ovf
  );

  // Divider side.
  modport slave (
    input  start, Dividend, Divisor,
    output Quotient, Remainder, busy, done, div_zero, ovf
  );
endinterface

// File: rtl/signed_div.sv
// Sequential signed divider: 2W-bit dividend / W-bit divisor, restoring
// shift-subtract on magnitudes, one quotient bit per clock, signs applied last.
module signed_div #(
  parameter int unsigned W = 5
) (
  input  logic        clk,
  input  logic        rst,
  signed_div_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIN = 2'd2} state_e;

  localparam int unsigned    CW       = $clog2(2*W + 1);
  localparam logic [2*W-1:0] MOST_NEG = {1'b1, {(2*W-1){1'b0}}};

  state_e         state_q, state_d;
  logic [2*W-1:0] dvd_q, dvd_d;      // dividend magnitude, becomes quotient magnitude
  logic [W:0]     prem_q, prem_d;    // partial remainder
  logic [W-1:0]   dvs_q, dvs_d;      // divisor magnitude
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           sgnq_q, sgnq_d;
  logic           sgnr_q, sgnr_d;
  logic           dz_q, dz_d;        // pending divide-by-zero for FIN
  logic [2*W-1:0] quot_q, quot_d;
  logic [W-1:0]   rem_q, rem_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           divz_q, divz_d;
  logic           ovf_q, ovf_d;

  logic           accept;
  logic           dvs_zero;
  logic [2*W-1:0] dvd_abs;
  logic [W-1:0]   dvs_abs;
  logic [W:0]     trial;
  logic [W:0]     diff;
  logic           ge;

  assign accept   = (state_q == IDLE) && bus.start;
  assign dvs_zero = (bus.Divisor == '0);
  assign dvd_abs  = bus.Dividend[2*W-1] ? -bus.Dividend : bus.Dividend;
  assign dvs_abs  = bus.Divisor[W-1]    ? -bus.Divisor  : bus.Divisor;
  assign trial    = {prem_q[W-1:0], dvd_q[2*W-1]};
  assign ge       = (trial >= {1'b0, dvs_q});
  assign diff     = trial - {1'b0, dvs_q};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = dvs_zero ? FIN : CALC;
      CALC: if (cnt_q == CW'(1)) state_d = FIN;
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values; results only change in FIN.
  always_comb begin
    dvd_d  = dvd_q;
    prem_d = prem_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    sgnq_d = sgnq_q;
    sgnr_d = sgnr_q;
    dz_d   = dz_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    busy_d = busy_q;
    done_d = 1'b0;
    divz_d = divz_q;
    ovf_d  = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (dvs_zero) begin
            dz_d = 1'b1;
          end else begin
            dz_d   = 1'b0;
            dvd_d  = dvd_abs;
            dvs_d  = dvs_abs;
            prem_d = '0;
            cnt_d  = CW'(2*W);
            sgnq_d = bus.Dividend[2*W-1] ^ bus.Divisor[W-1];
            sgnr_d = bus.Dividend[2*W-1];
            busy_d = 1'b1;
          end
        end
      end
      CALC: begin
        prem_d = ge ? diff : trial;
        dvd_d  = {dvd_q[2*W-2:0], ge};
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) busy_d = 1'b0;
      end
      FIN: begin
        done_d = 1'b1;
        busy_d = 1'b0;
        if (dz_q) begin
          quot_d = '0;
          rem_d  = '0;
          divz_d = 1'b1;
          ovf_d  = 1'b0;
        end else begin
          quot_d = sgnq_q ? -dvd_q : dvd_q;
          rem_d  = sgnr_q ? -prem_q[W-1:0] : prem_q[W-1:0];
          divz_d = 1'b0;
          ovf_d  = !sgnq_q && (dvd_q == MOST_NEG);
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_q  <= '0;
      prem_q <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      sgnq_q <= 1'b0;
      sgnr_q <= 1'b0;
      dz_q   <= 1'b0;
      quot_q <= '0;
      rem_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      divz_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      dvd_q  <= dvd_d;
      prem_q <= prem_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      sgnq_q <= sgnq_d;
      sgnr_q <= sgnr_d;
      dz_q   <= dz_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      busy_q <= busy_d;
      done_q <= done_d;
      divz_q <= divz_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.Quotient  = quot_q;
  assign bus.Remainder = rem_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.div_zero  = divz_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_signed_div.sv
// Directed bench for signed_div with hand-computed expected results.
module tb_signed_div;
  localparam int unsigned W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  signed_div_if #(.W(W)) bus ();

  signed_div #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present operands for one accepting edge, then scramble them.
  task automatic start_op(input logic [2*W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.Dividend = a;
    bus.Divisor  = b;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.Dividend = ~a;
    bus.Divisor  = ~b;
  endtask

  // Called at the negedge just after the accepting edge; lat_o counts edges to done.
  // poke_at >= 0 issues a stray 5/1 start at that cycle.
  task automatic wait_done(input int poke_at, output int lat_o, output int bcyc_o,
                           output int ovl_o, output logic [2*W-1:0] q0, output logic dz0);
    lat_o  = 0;
    bcyc_o = 0;
    ovl_o  = 0;
    q0     = bus.Quotient;
    dz0    = bus.div_zero;
    while (!bus.done && lat_o < 40) begin
      if (bus.busy) bcyc_o++;
      if (lat_o == poke_at) begin
        bus.start    = 1'b1;
        bus.Dividend = (2*W)'(5);
        bus.Divisor  = W'(1);
      end else if (poke_at >= 0 && lat_o == poke_at + 1) begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      lat_o++;
    end
    if (bus.busy && bus.done) ovl_o++;
  endtask

  task automatic run(input string tag, input logic [2*W-1:0] a, input logic [W-1:0] b,
                     input logic [2*W-1:0] eq, input logic [W-1:0] er,
                     input logic edz, input logic eovf, input int elat, input int ebusy);
    int lat, bcyc, ovl;
    logic [2*W-1:0] q0;
    logic dz0;
    start_op(a, b);
    wait_done(-1, lat, bcyc, ovl, q0, dz0);
    check({tag, "_lat"},  lat,           elat);
    check({tag, "_busy"}, bcyc,          ebusy);
    check({tag, "_ovl"},  ovl,           0);
    check({tag, "_q"},    bus.Quotient,  eq);
    check({tag, "_r"},    bus.Remainder, er);
    check({tag, "_dz"},   bus.div_zero,  edz);
    check({tag, "_ovf"},  bus.ovf,       eovf);
    @(negedge clk);
    check({tag, "_pulse"}, bus.done, 0);
  endtask

  initial begin
    int lat, bcyc, ovl, dones;
    logic [2*W-1:0] q0;
    logic dz0;

    bus.start    = 1'b0;
    bus.Dividend = '0;
    bus.Divisor  = '0;
    rst          = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_q",    bus.Quotient,  0);
    check("rst_r",    bus.Remainder, 0);
    check("rst_busy", bus.busy,      0);
    check("rst_done", bus.done,      0);
    check("rst_dz",   bus.div_zero,  0);
    check("rst_ovf",  bus.ovf,       0);
    rst = 1'b0;

    run("m40_4",   10'h3D8, 5'h04, 10'h3F6, 5'h00, 1'b0, 1'b0, 11, 10);
    run("110_m10", 10'h06E, 5'h16, 10'h3F5, 5'h00, 1'b0, 1'b0, 11, 10);
    run("7_m2",    10'h007, 5'h1E, 10'h3FD, 5'h01, 1'b0, 1'b0, 11, 10);
    run("m7_2",    10'h3F9, 5'h02, 10'h3FD, 5'h1F, 1'b0, 1'b0, 11, 10);
    run("m512_m1", 10'h200, 5'h1F, 10'h200, 5'h00, 1'b0, 1'b1, 11, 10);
    run("m512_1",  10'h200, 5'h01, 10'h200, 5'h00, 1'b0, 1'b0, 11, 10);
    run("100_0",   10'h064, 5'h00, 10'h000, 5'h00, 1'b1, 1'b0, 1,  0);

    // 100/7 with a stray 5/1 start mid-operation; old flags hold while busy.
    start_op(10'h064, 5'h07);
    wait_done(4, lat, bcyc, ovl, q0, dz0);
    check("hold_q",   q0,            0);
    check("hold_dz",  dz0,           1);
    check("ign_lat",  lat,           11);
    check("ign_q",    bus.Quotient,  10'h00E);
    check("ign_r",    bus.Remainder, 5'h02);
    check("ign_dz",   bus.div_zero,  0);
    repeat (2) @(negedge clk);
    check("ign_idle", bus.busy, 0);

    // start held high: second operation accepted right after FIN.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.Dividend = 10'h3D8;
    bus.Divisor  = 5'h04;
    @(negedge clk);
    bus.Dividend = 10'h007;
    bus.Divisor  = 5'h1E;
    wait_done(-1, lat, bcyc, ovl, q0, dz0);
    check("b2b1_lat", lat,           11);
    check("b2b1_q",   bus.Quotient,  10'h3F6);
    check("b2b1_r",   bus.Remainder, 5'h00);
    @(negedge clk);
    check("b2b_accept", bus.busy, 1);
    bus.start    = 1'b0;
    bus.Dividend = 10'h155;
    bus.Divisor  = 5'h0A;
    wait_done(-1, lat, bcyc, ovl, q0, dz0);
    check("b2b2_lat", lat,           11);
    check("b2b2_q",   bus.Quotient,  10'h3FD);
    check("b2b2_r",   bus.Remainder, 5'h01);

    // Reset in the middle of -33/11.
    start_op(10'h3DF, 5'h0B);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_q",    bus.Quotient,  0);
    check("abort_r",    bus.Remainder, 0);
    check("abort_busy", bus.busy,      0);
    check("abort_done", bus.done,      0);
    check("abort_dz",   bus.div_zero,  0);
    check("abort_ovf",  bus.ovf,       0);
    rst   = 1'b0;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) dones++;
    end
    check("abort_quiet", dones, 0);

    run("33_m11", 10'h021, 5'h15, 10'h3FD, 5'h00, 1'b0, 1'b0, 11, 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
